// File: rtl/pipeline_perf_monitor_if.sv
// Bundles the CPU-side event inputs and the monitor's counter/flag outputs.
// The master modport belongs to the CPU or bench side, and the slave modport belongs to the monitor.
interface pipeline_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic               start_i;
    logic               stall_i;
    logic               branch_i;
    logic               flush_i;
    logic               retire_i;
    logic [31:0]        pc_i;
    logic               snap_req_i;
    logic [CNT_W-1:0]   cycle_cnt_o;
    logic [CNT_W-1:0]   stall_cnt_o;
    logic [CNT_W-1:0]   flush_cnt_o;
    logic [CNT_W-1:0]   retire_cnt_o;
    logic [4*CNT_W-1:0] snap_data_o;
    logic               snap_valid_o;
    logic               hang_o;
    logic               done_o;

    modport master (
        output start_i, stall_i, branch_i, flush_i, retire_i, pc_i, snap_req_i,
        input  cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o,
               snap_data_o, snap_valid_o, hang_o, done_o
    );

    modport slave (
        input  start_i, stall_i, branch_i, flush_i, retire_i, pc_i, snap_req_i,
        output cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o,
               snap_data_o, snap_valid_o, hang_o, done_o
    );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Counts cycles, stalls, flushes and retirements until MAX_CYCLES, then stops.
// Also detects a PC that does not change and captures counter snapshots on request.
module pipeline_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30,
    parameter int WDOG_LIMIT = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pipeline_perf_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int              WD_W     = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(WDOG_LIMIT);

    state_t             state_q;
    logic               done_q;
    logic               hang_q;
    logic               snap_valid_q;
    logic [WD_W-1:0]    wdog_q;
    logic [WD_W-1:0]    wdog_d;
    logic [31:0]        last_pc_q;
    logic [4*CNT_W-1:0] cnt_all;
    logic [4*CNT_W-1:0] snap_q;
    logic [3:0]         evt;
    logic               count_en;

    // The edge that leaves IDLE is counted too, so the first edge with start high yields cycle 1.
    assign count_en = mon.start_i && (state_q != DONE);
    assign evt      = {mon.retire_i, mon.flush_i, mon.stall_i && !mon.branch_i, 1'b1};

    // Counter gi sits at cnt_all[gi*CNT_W +: CNT_W]; order {retire, flush, stall, cycle} matches snap_data_o.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (count_en && evt[gi] && (cnt_q != CNT_SAT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_all[gi*CNT_W +: CNT_W] = cnt_q;
    end

    always_comb begin
        wdog_d = '0;
        if ((mon.pc_i == last_pc_q) && !mon.stall_i) begin
            wdog_d = (wdog_q == WD_LIM) ? wdog_q : wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            hang_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            wdog_q       <= '0;
            last_pc_q    <= '0;
            snap_q       <= '0;
        end else begin
            snap_valid_q <= mon.snap_req_i;
            if (mon.snap_req_i) begin
                snap_q <= cnt_all;
            end
            if (count_en) begin
                last_pc_q <= mon.pc_i;
                wdog_q    <= wdog_d;
                if (wdog_d == WD_LIM) begin
                    hang_q <= 1'b1;
                end
                if (cnt_all[CNT_W-1:0] == LAST_CYC) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= RUN;
                end
            end else if (state_q == RUN) begin
                state_q <= IDLE;
            end
        end
    end

    assign mon.cycle_cnt_o  = cnt_all[0*CNT_W +: CNT_W];
    assign mon.stall_cnt_o  = cnt_all[1*CNT_W +: CNT_W];
    assign mon.flush_cnt_o  = cnt_all[2*CNT_W +: CNT_W];
    assign mon.retire_cnt_o = cnt_all[3*CNT_W +: CNT_W];
    assign mon.snap_data_o  = snap_q;
    assign mon.snap_valid_o = snap_valid_q;
    assign mon.hang_o       = hang_q;
    assign mon.done_o       = done_q;
endmodule
